// File: rtl/fetch_mem_responder_pkg.sv
// Shared fetch types: the exception code, the answer record and the exception classifier.
package fetch_mem_responder_pkg;

  typedef enum logic [1:0] {
    FETCH_EXC_NONE         = 2'd0,
    FETCH_EXC_MISALIGNED   = 2'd1,
    FETCH_EXC_ACCESS_FAULT = 2'd2
  } fetch_except_t;

  typedef struct packed {
    logic [63:0]   addr;
    logic [31:0]   instr;
    fetch_except_t exc;
  } fetch_ans_t;

  // Misalignment wins over the range check.
  function automatic fetch_except_t fetch_exc_calc(input logic [63:0] addr,
                                                   input logic [63:0] mem_bytes);
    if (addr[1:0] != 2'b00) return FETCH_EXC_MISALIGNED;
    if (addr >= mem_bytes) return FETCH_EXC_ACCESS_FAULT;
    return FETCH_EXC_NONE;
  endfunction

endpackage

// File: rtl/fetch_mem_responder_if.sv
// Fetch request/answer handshake between a fetch unit (master) and the responder (slave).
interface fetch_mem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] req_addr_i;
  logic        ans_valid_o;
  logic        ans_ready_i;
  logic [63:0] ans_addr_o;
  logic [31:0] ans_instr_o;
  logic [1:0]  ans_except_o;

  modport slave (
    input  req_valid_i, req_addr_i, ans_ready_i,
    output req_ready_o, ans_valid_o, ans_addr_o, ans_instr_o, ans_except_o
  );

  modport master (
    output req_valid_i, req_addr_i, ans_ready_i,
    input  req_ready_o, ans_valid_o, ans_addr_o, ans_instr_o, ans_except_o
  );
endinterface

// File: rtl/fetch_mem_responder_fifo.sv
// In-order answer FIFO, DEPTH entries; head visible combinationally, zero-latency pop.
// Never overflows: the parent's outstanding count gates every push.
module fetch_resp_fifo
  import fetch_mem_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       push_i,
  input  fetch_ans_t push_dat_i,
  input  logic       pop_i,
  output logic       empty_o,
  output fetch_ans_t head_dat_o
);
  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty; the low bits wrap modulo DEPTH.
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  fetch_ans_t  r_mem [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push_i) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop_i)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr[AW-1:0]] <= push_dat_i;
  end

  assign empty_o    = (r_wr_ptr == r_rd_ptr);
  assign head_dat_o = r_mem[r_rd_ptr[AW-1:0]];
endmodule

// File: rtl/fetch_mem_responder.sv
// Instruction-fetch responder: LATENCY-cycle request-to-answer delay, DEPTH outstanding, count-based ready.
// LEN5_FETCH_RESP_STALL_EN adds LFSR-driven stalls that block accepts and pops.
module fetch_mem_responder
  import fetch_mem_responder_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] MEM_BYTES = 64'h10000
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  fetch_mem_responder_if.slave        bus,
  output logic [63:0]                 mem_addr_o,
  input  logic [31:0]                 mem_rdata_i
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] r_cnt;
  logic          w_stall;
  logic          w_accept;
  logic          w_pop;
  fetch_except_t w_req_exc;
  logic          w_exit_vld;
  logic [63:0]   w_exit_addr;
  fetch_except_t w_exit_exc;
  logic          w_fifo_empty;
  fetch_ans_t    w_push_dat;
  fetch_ans_t    w_head;

`ifdef LEN5_FETCH_RESP_STALL_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  // Fibonacci taps 16,14,13,11.
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
  end

  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  assign bus.req_ready_o = (r_cnt < CW'(DEPTH)) && !flush_i && !w_stall;
  assign w_accept        = bus.req_valid_i && bus.req_ready_o;
  assign w_req_exc       = fetch_exc_calc(bus.req_addr_i, MEM_BYTES);
  assign w_pop           = !w_fifo_empty && bus.ans_ready_i && !w_stall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        r_cnt <= '0;
    else if (flush_i) r_cnt <= '0;
    else              r_cnt <= r_cnt + CW'(w_accept) - CW'(w_pop);
  end

  // The accept cycle is the first delay stage, so only LATENCY-1 register stages exist.
  generate
    if (LATENCY > 1) begin : g_dl
      logic          r_vld  [LATENCY-1];
      logic [63:0]   r_addr [LATENCY-1];
      fetch_except_t r_exc  [LATENCY-1];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < LATENCY-1; i++) begin
            r_vld[i]  <= 1'b0;
            r_addr[i] <= '0;
            r_exc[i]  <= FETCH_EXC_NONE;
          end
        end else if (flush_i) begin
          for (int i = 0; i < LATENCY-1; i++) r_vld[i] <= 1'b0;
        end else begin
          r_vld[0]  <= w_accept;
          r_addr[0] <= bus.req_addr_i;
          r_exc[0]  <= w_req_exc;
          for (int i = 1; i < LATENCY-1; i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_addr[i] <= r_addr[i-1];
            r_exc[i]  <= r_exc[i-1];
          end
        end
      end

      assign w_exit_vld  = r_vld[LATENCY-2];
      assign w_exit_addr = r_addr[LATENCY-2];
      assign w_exit_exc  = r_exc[LATENCY-2];
    end else begin : g_no_dl
      assign w_exit_vld  = w_accept;
      assign w_exit_addr = bus.req_addr_i;
      assign w_exit_exc  = w_req_exc;
    end
  endgenerate

  assign mem_addr_o = w_exit_vld ? {w_exit_addr[63:2], 2'b00} : '0;

  always_comb begin
    w_push_dat      = '0;
    w_push_dat.addr = w_exit_addr;
    w_push_dat.exc  = w_exit_exc;
    if (w_exit_exc == FETCH_EXC_NONE) w_push_dat.instr = mem_rdata_i;
  end

  fetch_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .push_i     (w_exit_vld && !flush_i),
    .push_dat_i (w_push_dat),
    .pop_i      (w_pop),
    .empty_o    (w_fifo_empty),
    .head_dat_o (w_head)
  );

  // Zeroed while empty so the answer bus reads 0 in reset and idle.
  assign bus.ans_valid_o  = !w_fifo_empty;
  assign bus.ans_addr_o   = w_fifo_empty ? '0 : w_head.addr;
  assign bus.ans_instr_o  = w_fifo_empty ? '0 : w_head.instr;
  assign bus.ans_except_o = w_fifo_empty ? 2'b00 : w_head.exc;
endmodule
